systolic_skew_feeder: RTL and testbench

- Edge driver for the N×N systolic MAC array. It buffers operand matrices A (N×K) and B (K×N), with K = N.
- Clears the array, then drives the row edges (a inputs, left column) and column edges (b inputs, top row) with diagonally skewed streams, so that cell (i,j) receives A[i][k] and B[k][j] on the same cycle.
- Signals done once the last product has accumulated, at which point all array data_mac outputs are valid.

---
 rtl/systolic_pkg.sv | 39 +++
 rtl/systolic_skew_feeder_if.sv | 46 ++++
 rtl/skew_lane.sv | 34 +++
 rtl/systolic_skew_feeder.sv | 146 ++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared types and sizing for the systolic array edge feeder:
//               sequencer states, feed-length helpers, operand matrix type.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  localparam int N_DEFAULT  = 4;
  localparam int DW_DEFAULT = 8;

  // Sequencer states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of FEED cycles for an n x n array: the last operand pair
  // reaches cell (n-1,n-1) at cnt = 3n-3.
  function automatic int feed_len(input int n);
    return 3 * n - 2;
  endfunction

  // Width of a counter spanning 0 .. feed_len(n)-1
  function automatic int cnt_width(input int n);
    return (feed_len(n) > 1) ? $clog2(feed_len(n)) : 1;
  endfunction

  localparam int FEED_LEN = feed_len(N_DEFAULT);
  localparam int CNT_W    = cnt_width(N_DEFAULT);

  // Operand matrix, indexed [row][col]
  typedef logic [N_DEFAULT-1:0][N_DEFAULT-1:0][DW_DEFAULT-1:0] operand_mat_t;

endpackage
`default_nettype wire

// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_skew_feeder_if
// Description : Operand write port, control handshake and array edge bus of
//               the systolic skew feeder.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_skew_feeder_if #(
  parameter int N  = systolic_pkg::N_DEFAULT,
  parameter int DW = systolic_pkg::DW_DEFAULT
);

  localparam int c_idx_w = $clog2(N);

  // Operand buffer write port
  logic               wr_en;
  logic               wr_sel;
  logic [c_idx_w-1:0] wr_row;
  logic [c_idx_w-1:0] wr_col;
  logic [DW-1:0]      wr_data;
  logic               wr_ready;

  // Control / status
  logic               start;
  logic               busy;
  logic               done;
  logic               array_clr;

  // Array edges: a_edge[i] -> cell (i,0), b_edge[j] -> cell (0,j)
  logic [N-1:0][DW-1:0] a_edge;
  logic [N-1:0][DW-1:0] b_edge;

  // Host / controller side
  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  wr_ready, busy, done, array_clr, a_edge, b_edge
  );

  // Feeder side
  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output wr_ready, busy, done, array_clr, a_edge, b_edge
  );

endinterface
`default_nettype wire

// File: rtl/skew_lane.sv
`default_nettype none
// ============================================================================
// Module      : skew_lane
// Description : One skewed edge lane. Lane LANE drives operand k on feed
//               cycle cnt = k + LANE and zero otherwise, which delays each
//               row/column by its index so operands meet on the diagonal.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_lane #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int CNT_W = 4,
  parameter int LANE  = 0
) (
  input  logic [CNT_W-1:0]   cnt,
  input  logic               feed_en,
  input  logic [N-1:0][DW-1:0] elems,
  output logic [DW-1:0]      lane_out
);

  // Select elems[cnt-LANE] while feeding and in range, else drive zero
  always_comb begin
    lane_out = '0;
    if (feed_en) begin
      for (int k = 0; k < N; k++) begin
        if (cnt == CNT_W'(LANE + k)) begin
          lane_out = elems[k];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_skew_feeder
// Description : Edge driver for an N x N systolic MAC array. Buffers A and B,
//               clears the array for one cycle, then streams diagonally
//               skewed rows of A and columns of B into the array edges and
//               flags done once the last product has accumulated.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_skew_feeder_if.slave bus
);

  localparam int                 c_cnt_w    = cnt_width(N);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(feed_len(N) - 1);

  state_e                      r_state;
  logic [c_cnt_w-1:0]          r_cnt;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_clr;
  logic                        r_wr_ready;
  logic [N-1:0][N-1:0][DW-1:0] r_mat_a;
  logic [N-1:0][N-1:0][DW-1:0] r_mat_b;

  logic                        w_wr_fire;
  logic                        w_feed;
  logic [N-1:0][DW-1:0]        w_a_edge;
  logic [N-1:0][DW-1:0]        w_b_edge;

  // Writes are only taken while the feeder is not reading the buffers
  assign w_wr_fire = bus.wr_en & r_wr_ready;
  assign w_feed    = (r_state == FEED);

  // Operand buffers: cleared on reset, loaded by accepted writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mat_a <= '0;
      r_mat_b <= '0;
    end else if (w_wr_fire) begin
      if (bus.wr_sel) begin
        r_mat_b[bus.wr_row][bus.wr_col] <= bus.wr_data;
      end else begin
        r_mat_a[bus.wr_row][bus.wr_col] <= bus.wr_data;
      end
    end
  end

  // Sequencer: IDLE -> CLEAR -> FEED (3N-2 cycles) -> DONE, status registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_clr      <= 1'b0;
      r_wr_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state    <= CLEAR;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_clr      <= 1'b1;
            r_wr_ready <= 1'b0;
          end
        end
        CLEAR: begin
          r_state <= FEED;
          r_cnt   <= '0;
          r_clr   <= 1'b0;
        end
        FEED: begin
          if (r_cnt == c_cnt_last) begin
            r_state    <= DONE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_wr_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_clr      <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  // One lane per A row and per B column; lane l is delayed by l cycles
  for (genvar l = 0; l < N; l++) begin : g_lane
    logic [N-1:0][DW-1:0] w_col_b;

    for (genvar k = 0; k < N; k++) begin : g_col
      assign w_col_b[k] = r_mat_b[k][l];
    end

    skew_lane #(
      .N     (N),
      .DW    (DW),
      .CNT_W (c_cnt_w),
      .LANE  (l)
    ) u_lane_a (
      .cnt      (r_cnt),
      .feed_en  (w_feed),
      .elems    (r_mat_a[l]),
      .lane_out (w_a_edge[l])
    );

    skew_lane #(
      .N     (N),
      .DW    (DW),
      .CNT_W (c_cnt_w),
      .LANE  (l)
    ) u_lane_b (
      .cnt      (r_cnt),
      .feed_en  (w_feed),
      .elems    (w_col_b),
      .lane_out (w_b_edge[l])
    );
  end

  assign bus.a_edge    = w_a_edge;
  assign bus.b_edge    = w_b_edge;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.array_clr = r_clr;
  assign bus.wr_ready  = r_wr_ready;

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_skew_feeder
// Description : Self-checking bench for systolic_skew_feeder. Drives a
//               behavioural N x N MAC array from the feeder edges and checks
//               edges, status and final products against matrix arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = $clog2(N);
  localparam int FL = 3 * N - 2;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  // Reference operand matrices
  int mdl_a [N][N];
  int mdl_b [N][N];

  // Behavioural MAC array fed by the DUT edges
  logic [DW-1:0] pa  [N][N];
  logic [DW-1:0] pb  [N][N];
  logic [15:0]   acc [N][N];

  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.N(N), .DW(DW)) bus ();

  systolic_skew_feeder #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] cell_a_in(input int i, input int j);
    if (j == 0) return bus.a_edge[i];
    return pa[i][j-1];
  endfunction

  function automatic logic [DW-1:0] cell_b_in(input int i, input int j);
    if (i == 0) return bus.b_edge[j];
    return pb[i-1][j];
  endfunction

  // Array cells: synchronous clear, one-cycle operand pass, 16-bit accumulate
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (bus.array_clr) begin
          acc[i][j] <= '0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + cell_a_in(i, j) * cell_b_in(i, j);
          pa[i][j]  <= cell_a_in(i, j);
          pb[i][j]  <= cell_b_in(i, j);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Row i of A enters k = c - i cycles late
  function automatic logic [N-1:0][DW-1:0] exp_a(input int c);
    logic [N-1:0][DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (c - i >= 0 && c - i < N) v[i] = DW'(mdl_a[i][c-i]);
    end
    return v;
  endfunction

  function automatic logic [N-1:0][DW-1:0] exp_b(input int c);
    logic [N-1:0][DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      if (c - j >= 0 && c - j < N) v[j] = DW'(mdl_b[c-j][j]);
    end
    return v;
  endfunction

  function automatic int prod(input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += mdl_a[i][k] * mdl_b[k][j];
    return s % 65536;
  endfunction

  task automatic check_status(input string tag, input bit e_busy, input bit e_done,
                              input bit e_clr, input bit e_rdy);
    check({tag, " busy"},      64'(bus.busy),      64'(e_busy));
    check({tag, " done"},      64'(bus.done),      64'(e_done));
    check({tag, " array_clr"}, 64'(bus.array_clr), 64'(e_clr));
    check({tag, " wr_ready"},  64'(bus.wr_ready),  64'(e_rdy));
  endtask

  task automatic wr(input bit sel, input int row, input int col, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_row  = IW'(row);
    bus.wr_col  = IW'(col);
    bus.wr_data = DW'(data);
    step();
    bus.wr_en   = 1'b0;
    if (sel) mdl_b[row][col] = data;
    else     mdl_a[row][col] = data;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        wr(1'b0, i, j, int'($urandom_range(0, 255)));
        wr(1'b1, i, j, int'($urandom_range(0, 255)));
      end
    end
  endtask

  // Full multiply: start, CLEAR, FEED cycle by cycle, DONE and products.
  // co_wr issues a write together with start; busy_wr hammers writes in FEED.
  task automatic run_mult(input string name, input bit co_wr, input bit co_sel,
                          input int co_row, input int co_col, input int co_data,
                          input bit busy_wr);
    bus.start = 1'b1;
    if (co_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_sel  = co_sel;
      bus.wr_row  = IW'(co_row);
      bus.wr_col  = IW'(co_col);
      bus.wr_data = DW'(co_data);
      if (co_sel) mdl_b[co_row][co_col] = co_data;
      else        mdl_a[co_row][co_col] = co_data;
    end
    step();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check_status({name, " clear"}, 1'b1, 1'b0, 1'b1, 1'b0);
    check({name, " clear a_edge"}, 64'(bus.a_edge), 64'd0);
    check({name, " clear b_edge"}, 64'(bus.b_edge), 64'd0);
    for (int t = 0; t < FL; t++) begin
      if (busy_wr) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = t[0];
        bus.wr_row  = IW'(t);
        bus.wr_col  = IW'(t + 1);
        bus.wr_data = DW'(42);
      end
      step();
      check($sformatf("%s a_edge cnt=%0d", name, t), 64'(bus.a_edge), 64'(exp_a(t)));
      check($sformatf("%s b_edge cnt=%0d", name, t), 64'(bus.b_edge), 64'(exp_b(t)));
      check_status($sformatf("%s feed cnt=%0d", name, t), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    bus.wr_en = 1'b0;
    step();
    check_status({name, " done"}, 1'b0, 1'b1, 1'b0, 1'b1);
    check({name, " done a_edge"}, 64'(bus.a_edge), 64'd0);
    check({name, " done b_edge"}, 64'(bus.b_edge), 64'd0);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        check($sformatf("%s C[%0d][%0d]", name, i, j), 64'(acc[i][j]), 64'(prod(i, j)));
      end
    end
  endtask

  // Watchdog so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_row  = '0;
    bus.wr_col  = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    rst         = 1'b1;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mdl_a[i][j] = 0;
        mdl_b[i][j] = 0;
      end
    end
    repeat (3) step();
    rst = 1'b0;

    // Reset then idle
    for (int t = 0; t < 3; t++) begin
      step();
      check_status($sformatf("idle %0d", t), 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("idle %0d a_edge", t), 64'(bus.a_edge), 64'd0);
      check($sformatf("idle %0d b_edge", t), 64'(bus.b_edge), 64'd0);
    end

    // Sparse skew pattern
    wr(1'b0, 1, 0, 5);
    wr(1'b0, 1, 3, 9);
    wr(1'b1, 2, 3, 7);
    run_mult("skew", 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Identity times B[k][j] = 4k+j
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        wr(1'b0, i, j, (i == j) ? 1 : 0);
        wr(1'b1, i, j, 4 * i + j);
      end
    end
    run_mult("ident", 1'b0, 1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        check($sformatf("ident const C[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(4 * i + j));
      end
    end

    // All operands 255: accumulator wraps to 63492
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        wr(1'b0, i, j, 255);
        wr(1'b1, i, j, 255);
      end
    end
    run_mult("max", 1'b0, 1'b0, 0, 0, 0, 1'b0);
    check("max const C[3][3]", 64'(acc[3][3]), 64'd63492);

    // Writes during FEED are dropped
    run_mult("busy_wr", 1'b0, 1'b0, 0, 0, 0, 1'b1);

    // Write and start in the same DONE cycle: new value is fed
    run_mult("co_wr", 1'b1, 1'b0, 2, 1, 3, 1'b0);
    run_mult("co_wr_b", 1'b1, 1'b1, 0, 3, 17, 1'b0);

    // Random matrices
    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_mult($sformatf("rand%0d", r), 1'b0, 1'b0, 0, 0, 0, 1'b0);
    end

    // Reset in the middle of FEED at cnt=5
    fill_random();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int t = 0; t <= 5; t++) step();
    check("pre_rst a_edge cnt=5", 64'(bus.a_edge), 64'(exp_a(5)));
    rst = 1'b1;
    #1;
    check_status("mid_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_rst a_edge", 64'(bus.a_edge), 64'd0);
    check("mid_rst b_edge", 64'(bus.b_edge), 64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mdl_a[i][j] = 0;
        mdl_b[i][j] = 0;
      end
    end
    step();
    run_mult("post_rst_zero", 1'b0, 1'b0, 0, 0, 0, 1'b0);
    fill_random();
    run_mult("post_rst_rand", 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Start while busy is ignored: a second start mid-FEED must not restart
    fill_random();
    bus.start = 1'b1;
    step();
    step();
    step();
    bus.start = 1'b0;
    for (int t = 2; t < FL; t++) step();
    check("start_busy a_edge cnt=9", 64'(bus.a_edge), 64'(exp_a(FL - 1)));
    step();
    check_status("start_busy done", 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        check($sformatf("start_busy C[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(prod(i, j)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
